// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle master: one local command in, one bus cycle out, one response pulse back.
// Build option: define WB_CMD_MASTER_RETRY_EN to re-issue cycles after RTY (up to MAX_RETRY times).
module wb_cmd_master #(
  parameter int dw        = 32,
  parameter int aw        = 32,
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [aw-1:0] cmd_adr,
  input  logic [dw-1:0] cmd_dat,
  input  logic [3:0]    cmd_sel,
  output logic          rsp_valid,
  output logic [dw-1:0] rsp_dat,
  output logic [1:0]    rsp_status,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  output logic [2:0]    wb_cti_o,
  output logic [1:0]    wb_bte_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i
);

  localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TO  = 2'b11;

`ifdef WB_CMD_MASTER_RETRY_EN
  localparam int RW = ($clog2(MAX_RETRY + 1) < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, BUS, BACKOFF} state_t;
  logic [RW-1:0] retry_cnt;
`else
  typedef enum logic [1:0] {IDLE, BUS} state_t;
`endif

  state_t        state;
  logic [CW-1:0] to_cnt;

  assign cmd_ready = (state == IDLE);
  assign wb_cti_o  = 3'b000;
  assign wb_bte_o  = 2'b00;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state      <= IDLE;
      wb_cyc_o   <= 1'b0;
      wb_stb_o   <= 1'b0;
      wb_we_o    <= 1'b0;
      wb_adr_o   <= '0;
      wb_dat_o   <= '0;
      wb_sel_o   <= '0;
      rsp_valid  <= 1'b0;
      rsp_dat    <= '0;
      rsp_status <= ST_OK;
      to_cnt     <= '0;
`ifdef WB_CMD_MASTER_RETRY_EN
      retry_cnt  <= '0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wb_adr_o <= cmd_adr;
            wb_dat_o <= cmd_dat;
            wb_sel_o <= cmd_sel;
            wb_we_o  <= cmd_we;
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            to_cnt   <= '0;
`ifdef WB_CMD_MASTER_RETRY_EN
            retry_cnt <= '0;
`endif
            state    <= BUS;
          end
        end
        BUS: begin
          // Termination priority is err > rty > ack; the timeout only fires on a quiet cycle.
          if (wb_err_i) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_dat    <= '0;
            rsp_status <= ST_ERR;
            state      <= IDLE;
          end else if (wb_rty_i) begin
`ifdef WB_CMD_MASTER_RETRY_EN
            if (retry_cnt < RETRY_LIM) begin
              retry_cnt <= retry_cnt + 1'b1;
              wb_cyc_o  <= 1'b0;
              wb_stb_o  <= 1'b0;
              state     <= BACKOFF;
            end else begin
              wb_cyc_o   <= 1'b0;
              wb_stb_o   <= 1'b0;
              rsp_valid  <= 1'b1;
              rsp_dat    <= '0;
              rsp_status <= ST_RTY;
              state      <= IDLE;
            end
`else
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_dat    <= '0;
            rsp_status <= ST_RTY;
            state      <= IDLE;
`endif
          end else if (wb_ack_i) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_dat    <= wb_we_o ? '0 : wb_dat_i;
            rsp_status <= ST_OK;
            state      <= IDLE;
          end else if (TIMEOUT != 0 && to_cnt == TO_LAST) begin
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_dat    <= '0;
            rsp_status <= ST_TO;
            state      <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
`ifdef WB_CMD_MASTER_RETRY_EN
        BACKOFF: begin
          // Address/data/select registers still hold the original command.
          wb_cyc_o <= 1'b1;
          wb_stb_o <= 1'b1;
          to_cnt   <= '0;
          state    <= BUS;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// Randomized self-checking bench for wb_cmd_master with a scripted slave and an outcome model.
// Honors WB_CMD_MASTER_RETRY_EN so the same bench covers both builds.
module tb_wb_cmd_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int TO = 8;
  localparam int MR = 3;
`ifdef WB_CMD_MASTER_RETRY_EN
  localparam bit RETRY_ON = 1'b1;
`else
  localparam bit RETRY_ON = 1'b0;
`endif

  logic          wb_clk, wb_rst;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;
  logic [3:0]    cmd_sel;
  logic          rsp_valid;
  logic [DW-1:0] rsp_dat;
  logic [1:0]    rsp_status;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel_o;
  logic          wb_we_o, wb_cyc_o, wb_stb_o;
  logic [2:0]    wb_cti_o;
  logic [1:0]    wb_bte_o;
  logic [DW-1:0] wb_dat_i;
  logic          wb_ack_i, wb_err_i, wb_rty_i;

  wb_cmd_master #(.dw(DW), .aw(AW), .TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_dat(cmd_dat), .cmd_sel(cmd_sel),
    .rsp_valid(rsp_valid), .rsp_dat(rsp_dat), .rsp_status(rsp_status),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_cti_o(wb_cti_o), .wb_bte_o(wb_bte_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Slave script: per attempt, wait cycles before terminating and the {err,rty,ack} pattern.
  int          att_wait[4];
  logic [2:0]  att_term[4];
  logic [31:0] att_dat[4];

  logic [1:0]  obs_status;
  logic [31:0] obs_dat;
  int          obs_stb, obs_phases, obs_gaps, obs_bad_bus, obs_bad_ready;
  bit          obs_started, obs_ready_issue, obs_done;

  logic [1:0]  exp_st;
  logic [31:0] exp_dat;
  int          exp_stb, exp_phases;

  // Outcome of one command given the slave script: err beats rty beats ack, and a
  // phase longer than the timeout allowance is cut off after TO strobe cycles.
  function automatic void model(input logic we, output logic [1:0] st, output logic [31:0] d,
                                output int stb_cycles, output int phases);
    stb_cycles = 0; phases = 0; st = 2'b00; d = '0;
    for (int a = 0; a < 4; a++) begin
      phases++;
      if (att_wait[a] >= TO) begin stb_cycles += TO; st = 2'b11; return; end
      stb_cycles += att_wait[a] + 1;
      if (att_term[a][2]) begin st = 2'b01; return; end
      if (att_term[a][1]) begin
        if (RETRY_ON && a < MR) continue;
        st = 2'b10; return;
      end
      st = 2'b00; d = we ? 32'h0 : att_dat[a]; return;
    end
  endfunction

  task automatic drive_noise();
    wb_ack_i = 1'($urandom_range(0, 1));
    wb_err_i = 1'($urandom_range(0, 1));
    wb_rty_i = 1'($urandom_range(0, 1));
    wb_dat_i = $urandom();
  endtask

  // Issues one command at a negedge and plays the slave script until the response.
  task automatic run_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
    int ai, pc, budget;
    bit prev, hit;
    obs_status = 'x; obs_dat = 'x; obs_stb = 0; obs_phases = 0; obs_gaps = 0;
    obs_bad_bus = 0; obs_bad_ready = 0; obs_done = 0;
    cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel; cmd_valid = 1'b1;
    obs_ready_issue = cmd_ready;
    @(posedge wb_clk);
    @(negedge wb_clk);
    cmd_valid = 1'b0;
    cmd_adr = $urandom(); cmd_dat = $urandom(); cmd_sel = 4'($urandom()); cmd_we = ~we;
    obs_started = wb_stb_o && wb_cyc_o;
    if (!obs_started) return;
    ai = 0; pc = 0; prev = 1'b0; budget = 0;
    forever begin
      if (rsp_valid) begin
        obs_done = 1; obs_status = rsp_status; obs_dat = rsp_dat;
        break;
      end
      budget++;
      if (budget > 200) break;
      if (cmd_ready) obs_bad_ready++;
      if (wb_stb_o) begin
        if (!prev) begin obs_phases++; pc = 0; end
        obs_stb++;
        if (!wb_cyc_o || wb_we_o !== we || wb_adr_o !== adr || wb_dat_o !== dat ||
            wb_sel_o !== sel || wb_cti_o !== 3'b000 || wb_bte_o !== 2'b00)
          obs_bad_bus++;
        hit = (ai < 4) && (pc == att_wait[ai]);
        if (hit) begin
          {wb_err_i, wb_rty_i, wb_ack_i} = att_term[ai];
          wb_dat_i = att_dat[ai];
        end else begin
          {wb_err_i, wb_rty_i, wb_ack_i} = 3'b000;
          wb_dat_i = $urandom();
        end
        pc++;
      end else begin
        if (prev) ai++;
        if (wb_cyc_o) obs_bad_bus++;
        obs_gaps++;
        drive_noise();
      end
      prev = wb_stb_o;
      @(negedge wb_clk);
    end
    drive_noise();
  endtask

  task automatic test_reset();
    wb_rst = 1'b1;
    repeat (3) begin drive_noise(); @(negedge wb_clk); end
    n_checks++;
    if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: cyc=%b stb=%b we=%b adr=%h dat=%h sel=%h, want all 0",
               wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o);
    end
    n_checks++;
    if ({rsp_valid, rsp_dat, rsp_status} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: valid=%b dat=%h status=%b, want 0/0/00", rsp_valid, rsp_dat, rsp_status);
    end
    wb_rst = 1'b0;
    @(negedge wb_clk);
    n_checks++;
    if (cmd_ready !== 1'b1 || wb_cti_o !== 3'b000 || wb_bte_o !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_idle: cmd_ready=%b cti=%b bte=%b, want 1/000/00", cmd_ready, wb_cti_o, wb_bte_o);
    end
  endtask

  task automatic test_write_zero_wait();
    att_wait[0] = 0; att_term[0] = 3'b001; att_dat[0] = $urandom();
    run_cmd(1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF);
    n_checks++;
    if (!obs_ready_issue || !obs_started || !obs_done) begin
      n_fail++;
      $display("FAIL wr0_flow: ready=%b started=%b done=%b, want 1/1/1", obs_ready_issue, obs_started, obs_done);
    end
    n_checks++;
    if (obs_stb !== 1 || obs_bad_bus !== 0) begin
      n_fail++;
      $display("FAIL wr0_stb: stb_cycles=%0d bad_bus=%0d, want 1/0", obs_stb, obs_bad_bus);
    end
    n_checks++;
    if (obs_status !== 2'b00 || obs_dat !== 32'h0) begin
      n_fail++;
      $display("FAIL wr0_rsp: status=%b dat=%h, want 00/00000000", obs_status, obs_dat);
    end
  endtask

  task automatic test_read_wait3();
    att_wait[0] = 3; att_term[0] = 3'b001; att_dat[0] = 32'h1234_5678;
    run_cmd(1'b0, 32'h0000_0008, $urandom(), 4'h3);
    n_checks++;
    if (obs_stb !== 4 || obs_bad_ready !== 0 || obs_bad_bus !== 0) begin
      n_fail++;
      $display("FAIL rd3_bus: stb_cycles=%0d ready_hi=%0d bad_bus=%0d, want 4/0/0",
               obs_stb, obs_bad_ready, obs_bad_bus);
    end
    n_checks++;
    if (obs_status !== 2'b00 || obs_dat !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL rd3_rsp: status=%b dat=%h, want 00/12345678", obs_status, obs_dat);
    end
    @(negedge wb_clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rd3_pulse: rsp_valid=%b cmd_ready=%b one cycle later, want 0/1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_ack_err();
    att_wait[0] = $urandom_range(0, 3); att_term[0] = 3'b101; att_dat[0] = 32'hA5A5_0001;
    run_cmd(1'b0, $urandom(), $urandom(), 4'hF);
    n_checks++;
    if (obs_status !== 2'b01 || obs_dat !== 32'h0 || obs_stb !== att_wait[0] + 1) begin
      n_fail++;
      $display("FAIL ackerr: status=%b dat=%h stb=%0d, want 01/00000000/%0d",
               obs_status, obs_dat, obs_stb, att_wait[0] + 1);
    end
  endtask

  task automatic test_timeout_back_to_back();
    att_wait[0] = 1000; att_term[0] = 3'b001; att_dat[0] = '0;
    run_cmd(1'b0, $urandom(), $urandom(), 4'hF);
    n_checks++;
    if (obs_status !== 2'b11 || obs_stb !== TO || obs_dat !== 32'h0) begin
      n_fail++;
      $display("FAIL timeout: status=%b stb=%0d dat=%h, want 11/%0d/00000000", obs_status, obs_stb, obs_dat, TO);
    end
    att_wait[0] = 0; att_term[0] = 3'b001; att_dat[0] = 32'hCAFE_F00D;
    run_cmd(1'b0, $urandom(), $urandom(), 4'h1);
    n_checks++;
    if (!obs_ready_issue || !obs_started || obs_status !== 2'b00 || obs_dat !== 32'hCAFE_F00D) begin
      n_fail++;
      $display("FAIL b2b: ready=%b started=%b status=%b dat=%h, want 1/1/00/cafef00d",
               obs_ready_issue, obs_started, obs_status, obs_dat);
    end
  endtask

  task automatic test_retry();
    att_wait[0] = 1; att_term[0] = 3'b010; att_dat[0] = $urandom();
    att_wait[1] = 0; att_term[1] = 3'b010; att_dat[1] = $urandom();
    att_wait[2] = 2; att_term[2] = 3'b001; att_dat[2] = 32'h0BAD_F00D;
    att_wait[3] = 0; att_term[3] = 3'b001; att_dat[3] = $urandom();
    run_cmd(1'b0, $urandom(), $urandom(), 4'hC);
    n_checks++;
    if (obs_status !== (RETRY_ON ? 2'b00 : 2'b10) || obs_phases !== (RETRY_ON ? 3 : 1) ||
        obs_gaps !== (RETRY_ON ? 2 : 0) || obs_bad_bus !== 0) begin
      n_fail++;
      $display("FAIL rty2ack: status=%b phases=%0d gaps=%0d bad_bus=%0d, retry_on=%0d",
               obs_status, obs_phases, obs_gaps, obs_bad_bus, RETRY_ON);
    end
    n_checks++;
    if (obs_dat !== (RETRY_ON ? 32'h0BAD_F00D : 32'h0)) begin
      n_fail++;
      $display("FAIL rty2ack_dat: dat=%h, retry_on=%0d", obs_dat, RETRY_ON);
    end
    for (int a = 0; a < 4; a++) begin
      att_wait[a] = $urandom_range(0, 2); att_term[a] = 3'b010; att_dat[a] = $urandom();
    end
    run_cmd(1'b1, $urandom(), $urandom(), 4'hF);
    n_checks++;
    if (obs_status !== 2'b10 || obs_phases !== (RETRY_ON ? 4 : 1) || obs_dat !== 32'h0) begin
      n_fail++;
      $display("FAIL rty_always: status=%b phases=%0d dat=%h, want 10/%0d/0",
               obs_status, obs_phases, obs_dat, RETRY_ON ? 4 : 1);
    end
  endtask

  task automatic test_random();
    logic        we;
    logic [31:0] adr, dat;
    logic [3:0]  sel;
    for (int n = 0; n < 40; n++) begin
      for (int a = 0; a < 4; a++) begin
        att_wait[a] = $urandom_range(0, 10);
        att_term[a] = 3'($urandom_range(1, 7));
        att_dat[a]  = $urandom();
      end
      we = 1'($urandom_range(0, 1)); adr = $urandom(); dat = $urandom(); sel = 4'($urandom());
      model(we, exp_st, exp_dat, exp_stb, exp_phases);
      run_cmd(we, adr, dat, sel);
      n_checks++;
      if (obs_status !== exp_st || obs_dat !== exp_dat) begin
        n_fail++;
        $display("FAIL rnd%0d_rsp: status=%b dat=%h, want %b/%h", n, obs_status, obs_dat, exp_st, exp_dat);
      end
      n_checks++;
      if (obs_stb !== exp_stb || obs_phases !== exp_phases || obs_gaps !== exp_phases - 1) begin
        n_fail++;
        $display("FAIL rnd%0d_shape: stb=%0d phases=%0d gaps=%0d, want %0d/%0d/%0d",
                 n, obs_stb, obs_phases, obs_gaps, exp_stb, exp_phases, exp_phases - 1);
      end
      n_checks++;
      if (!obs_started || obs_bad_bus !== 0 || obs_bad_ready !== 0) begin
        n_fail++;
        $display("FAIL rnd%0d_bus: started=%b bad_bus=%0d ready_hi=%0d, want 1/0/0",
                 n, obs_started, obs_bad_bus, obs_bad_ready);
      end
      if ($urandom_range(0, 1) == 1) begin
        @(negedge wb_clk);
        drive_noise();
        n_checks++;
        if (rsp_valid !== 1'b0 || wb_cyc_o !== 1'b0 || cmd_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL rnd%0d_idle: rsp_valid=%b cyc=%b cmd_ready=%b, want 0/0/1",
                   n, rsp_valid, wb_cyc_o, cmd_ready);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int rsp_seen = 0;
    cmd_we = 1'b0; cmd_adr = $urandom(); cmd_dat = $urandom(); cmd_sel = 4'hF; cmd_valid = 1'b1;
    {wb_err_i, wb_rty_i, wb_ack_i} = 3'b000;
    @(posedge wb_clk);
    @(negedge wb_clk);
    cmd_valid = 1'b0;
    repeat (2) @(negedge wb_clk);
    n_checks++;
    if (wb_stb_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_pre: stb=%b before reset, want 1", wb_stb_o);
    end
    wb_rst = 1'b1;
    @(negedge wb_clk);
    n_checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_drop: cyc=%b stb=%b rsp_valid=%b, want 0/0/0", wb_cyc_o, wb_stb_o, rsp_valid);
    end
    wb_rst = 1'b0;
    {wb_err_i, wb_rty_i, wb_ack_i} = 3'b111;
    repeat (4) begin
      @(negedge wb_clk);
      if (rsp_valid) rsp_seen++;
    end
    n_checks++;
    if (rsp_seen !== 0 || cmd_ready !== 1'b1 || wb_cyc_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_after: rsp_pulses=%0d cmd_ready=%b cyc=%b, want 0/1/0", rsp_seen, cmd_ready, wb_cyc_o);
    end
    {wb_err_i, wb_rty_i, wb_ack_i} = 3'b000;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0; cmd_sel = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    @(negedge wb_clk);
    test_reset();
    test_write_zero_wait();
    test_read_wait3();
    test_ack_err();
    test_timeout_back_to_back();
    test_retry();
    test_random();
    test_reset_mid();
    repeat (2) @(negedge wb_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
